dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-port data memory (address_rw/data_in/data_out/
//  memory_write_enable) between N_REQ requesters: GPP cores and the router DMA port.
//  Sits between the GPP datapaths and the data memory. Grants one owner at a time.
//  Bounds ownership to MAX_HOLD transfers when others wait; returns read data with valid.
// PARAMETERS
//  N_REQ    4   number of requesters (2..8)
//  ADDR_W   5   data memory address width
//  DATA_W   16  data word width
//  MAX_HOLD 8   max consecutive transfers per grant while another requester is pending (>=1)
// PORTS
//  clk                  in   1               system clock, all state on rising edge
//  rst                  in   1               synchronous active-high reset
//  req                  in   N_REQ           per-requester access request (level)
//  we                   in   N_REQ           per-requester write enable (1=write,0=read)
//  addr                 in   N_REQ*ADDR_W    per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//  wdata                in   N_REQ*DATA_W    per-requester write data, same slicing
//  gnt                  out  N_REQ           registered one-hot-or-zero grant
//  rvalid               out  N_REQ           read data valid, one-hot-or-zero, 1 cycle
//  rdata                out  DATA_W          read data (shared), meaningful when any rvalid
//  address_rw           out  ADDR_W          to data memory
//  data_in              out  DATA_W          to data memory
//  memory_write_enable  out  1               to data memory
//  data_out             in   DATA_W          from data memory, 1-cycle registered read
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, rdata=0, state=IDLE, hold_cnt=0, rr_ptr=0 (req[0] highest first).
//  Transfer: a cycle where gnt[i]&req[i]=1. Memory ports driven combinationally from slice i:
//   address_rw=addr[i], data_in=wdata[i], memory_write_enable=we[i]. No transfer ->
//   address_rw=0, data_in=0, memory_write_enable=0.
//  Read latency: read transfer in cycle t -> rvalid[i]=1, rdata=data_out in cycle t+1.
//   rdata holds last value when rvalid=0. Write transfers never raise rvalid.
//  FSM IDLE: gnt=0. If any req, at edge grant first requester searching rr_ptr, rr_ptr+1,..
//   (mod N_REQ); go OWN, hold_cnt=0. Grant latency = 1 cycle after req rises.
//  FSM OWN (owner o):
//   - req[o]=0: no transfer; at edge pick next requester from o+1 (mod N_REQ) excluding o;
//     none -> IDLE, gnt=0. rr_ptr=o+1.
//   - transfer and hold_cnt==MAX_HOLD-1 and any other req: rotate at edge to next requester
//     after o; hold_cnt=0; rr_ptr=o+1. No gap cycle between owners.
//   - transfer otherwise: hold_cnt++ (saturate at MAX_HOLD-1 when no other req pending).
//  Handshake: requester holds req/we/addr/wdata stable until it sees gnt; each cycle with
//   gnt&req consumes one access. Losing gnt mid-stream: the access in the cycle gnt fell
//   was not performed; requester retries when regranted.
//  gnt is never multi-hot; memory_write_enable only asserted during a transfer.
//  rr_ptr wraps N_REQ-1 -> 0. Unused rr_ptr values (non-power-of-2 N_REQ) never occur.
//  Reset mid-transfer: next cycle gnt=0, rvalid=0, IDLE; pending read data is dropped.
//  Simultaneous: owner dropping req while hold limit reached -> treated as release.
// TESTING
//  1. Reset then req=0001, we=0, addr0=3 -> gnt=0001 next cycle; rvalid[0] cycle after, rdata=mem[3].
//  2. req=0001 write addr0=7 wdata0=16'hBEEF, then read 7 -> memory_write_enable 1 cycle, rdata=16'hBEEF.
//  3. req=1111 all held -> grants rotate 0,1,2,3,0 each after exactly 8 transfers, no idle gap.
//  4. req[2] alone held 20 cycles -> gnt stays 0100, 20 transfers, no forced rotation.
//  5. Owner 1 drops req while req[3],req[0] pending -> next gnt=1000, then 0001 after release.
//  6. rst asserted during owner read -> next cycle gnt=0, rvalid=0, memory_write_enable=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the requester-side and memory-side signals of the
// data memory arbiter.
//   req, we, addr, wdata    per-requester access request, packed slice i per requester
//   gnt, rvalid, rdata      grant and read return to the requesters
//   address_rw, data_in,
//   memory_write_enable     single-port data memory command
//   data_out                data memory read data (one cycle after the address)
// Modports: slave = the arbiter, master = requesters plus memory (the environment).
interface dmem_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       address_rw;
  logic [DATA_W-1:0]       data_in;
  logic                    memory_write_enable;
  logic [DATA_W-1:0]       data_out;

  modport slave (
    input  req, we, addr, wdata, data_out,
    output gnt, rvalid, rdata, address_rw, data_in, memory_write_enable
  );

  modport master (
    output req, we, addr, wdata, data_out,
    input  gnt, rvalid, rdata, address_rw, data_in, memory_write_enable
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory between
// N_REQ requesters. One owner at a time; the owner keeps the memory for at most
// MAX_HOLD consecutive transfers while anybody else is waiting.
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  dmem_arbiter_if.slave: requester request/grant/read return and the
//        memory command/read data (see the interface header)
module dmem_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e             state_q;
  idx_t               owner_q;
  idx_t               rr_ptr_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(N_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input idx_t i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Returns {found, index} of the first set bit of r searching start, start+1, ...
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r, input idx_t start);
    logic [IDX_W:0] res;
    idx_t           j;
    res = '0;
    j   = start;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!res[IDX_W] && r[j]) res = {1'b1, j};
      j = next_idx(j);
    end
    return res;
  endfunction

  logic             xfer;
  logic [N_REQ-1:0] owner_oh;
  logic             others_req;
  logic [IDX_W:0]   pick_idle;
  logic [IDX_W:0]   pick_next;

  assign owner_oh   = to_onehot(owner_q);
  assign xfer       = (state_q == StOwn) && bus.req[owner_q];
  assign others_req = |(bus.req & ~owner_oh);
  assign pick_idle  = pick(bus.req, rr_ptr_q);
  // The current owner is excluded when handing over.
  assign pick_next  = pick(bus.req & ~owner_oh, next_idx(owner_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= (xfer && !bus.we[owner_q]) ? owner_oh : '0;
      // Keep the last returned word so rdata holds while rvalid is low.
      if (rvalid_q != '0) rdata_q <= bus.data_out;

      unique case (state_q)
        StIdle: begin
          if (pick_idle[IDX_W]) begin
            state_q    <= StOwn;
            owner_q    <= pick_idle[IDX_W-1:0];
            gnt_q      <= to_onehot(pick_idle[IDX_W-1:0]);
            hold_cnt_q <= '0;
          end
        end
        StOwn: begin
          if (!bus.req[owner_q]) begin
            // Release (also covers release coinciding with the hold limit).
            rr_ptr_q   <= next_idx(owner_q);
            hold_cnt_q <= '0;
            if (pick_next[IDX_W]) begin
              owner_q <= pick_next[IDX_W-1:0];
              gnt_q   <= to_onehot(pick_next[IDX_W-1:0]);
            end else begin
              state_q <= StIdle;
              gnt_q   <= '0;
            end
          end else if (hold_cnt_q == HoldLast && others_req) begin
            // Forced rotation: others_req guarantees pick_next found someone.
            rr_ptr_q   <= next_idx(owner_q);
            hold_cnt_q <= '0;
            owner_q    <= pick_next[IDX_W-1:0];
            gnt_q      <= to_onehot(pick_next[IDX_W-1:0]);
          end else if (hold_cnt_q != HoldLast) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.address_rw          = '0;
    bus.data_in             = '0;
    bus.memory_write_enable = 1'b0;
    if (xfer) begin
      bus.address_rw          = bus.addr[int'(owner_q) * ADDR_W +: ADDR_W];
      bus.data_in             = bus.wdata[int'(owner_q) * DATA_W +: DATA_W];
      bus.memory_write_enable = bus.we[owner_q];
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  // Memory read data is registered by the RAM, so it is presented in the cycle after the read.
  assign bus.rdata  = (rvalid_q != '0) ? bus.data_out : rdata_q;

endmodule
